truth_table_checker: RTL
========================

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter N_IN, default 2, number of inputs of the gate under test (1..6).
REQ-002 Parameter EXPECTED, default 4'b1000, golden truth table, width 2**N_IN; bit k is the expected output for input vector k.
REQ-003 Parameter SETTLE, default 1, cycles each vector is driven before sampling (1..15).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to begin a sweep; sampled only in IDLE.
REQ-007 dut_in  output  N_IN  input vector driven to the gate under test.
REQ-008 dut_out  input  1  output of the gate under test, combinational from dut_in.
REQ-009 busy  output  1  high in DRIVE and SAMPLE.
REQ-010 done  output  1  one-cycle pulse when a sweep ends.
REQ-011 pass  output  1  result of the last completed sweep: 1 = no mismatch.
REQ-012 err_count  output  N_IN+1  mismatches in the current or last sweep.
REQ-013 first_fail  output  N_IN  lowest vector index that mismatched; 0 if none.

Function
REQ-014 FSM states SHALL be IDLE, DRIVE, SAMPLE, DONE.
REQ-015 IDLE with start=1 SHALL go to DRIVE; dut_in:=0, err_count:=0, first_fail:=0, pass:=0, settle counter:=SETTLE.
REQ-016 DRIVE SHALL hold dut_in for exactly SETTLE cycles, then go to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle and compare dut_out with EXPECTED[dut_in]; on mismatch increment err_count, and on the first mismatch load first_fail:=dut_in.
REQ-018 After SAMPLE, if dut_in is all ones, go to DONE; otherwise dut_in:=dut_in+1, reload the counter, and go to DRIVE.
REQ-019 DONE SHALL last one cycle with done=1 and pass:=(err_count==0 including the final sample), then return to IDLE.
REQ-020 Sweep latency: done high exactly (2**N_IN)*(SETTLE+1)+1 cycles after the edge that accepted start (9 for the defaults).
REQ-021 start while busy or in DONE SHALL be ignored; no queueing.
REQ-022 err_count SHALL not overflow; the width N_IN+1 holds a maximum of 2**N_IN.
REQ-023 dut_in, err_count, first_fail and pass SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-024 rst=1 SHALL force IDLE at the next edge, including mid-sweep; dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail=0.
REQ-025 rst has priority over start in the same cycle.

Configuration
REQ-026 Macro TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN, when defined: on the first mismatch in SAMPLE, go directly to DONE (pass=0, err_count=1, dut_in held at the failing vector).
REQ-027 When the macro is undefined: all 2**N_IN vectors are always swept (REQ-018).

Structure
REQ-028 Package truth_table_checker_pkg SHALL hold the state enum type and the SETTLE counter width constant (4).
REQ-029 One sub-module, settle_counter: loadable down-counter with a zero flag, used for DRIVE timing.

Verification
REQ-030 Defaults with an ideal AND gate (dut_out=&dut_in), start pulse -> dut_in steps 0,1,2,3; done at cycle 9; pass=1; err_count=0.
REQ-031 Defaults with an OR gate as DUT -> pass=0, err_count=2, first_fail=1; done at cycle 9 (macro undefined). With the macro defined -> done at cycle 5, err_count=1, dut_in=1.
REQ-032 SETTLE=3 with the AND gate -> each vector is held 3 cycles before sampling; done at cycle 17.
REQ-033 rst asserted 3 cycles into a sweep -> next cycle busy=0, dut_in=0, err_count=0; a new start then completes a normal sweep.
REQ-034 start held high continuously -> a sweep restarts only in IDLE, done pulses every 10 cycles; start pulses during busy are ignored.
REQ-035 N_IN=3, EXPECTED=8'h80, 3-input AND -> 8 vectors, pass=1; inject a stuck-at-0 dut_out -> err_count=1, first_fail=7.

Source files
------------

// File: rtl/truth_table_checker_pkg.sv
// truth_table_checker_pkg: sweep FSM state type and settle counter width shared by the checker files
package truth_table_checker_pkg;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
endpackage

// File: rtl/truth_table_checker_settle_counter.sv
// settle_counter: loadable down-counter timing how long each vector is driven
// ports: clk, rst (sync active-high), load/load_val (preset count), en (count down),
//        zero (count reaches zero on this edge, so this is the last enabled cycle)
module settle_counter
  import truth_table_checker_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - CNT_W'(1);
  assign zero = en && cnt == CNT_W'(1);
endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every input vector of a gate and compares its output against a golden truth table
// ports: clk, rst (sync active-high), start (begin sweep, taken only in IDLE), dut_in (vector to gate),
//        dut_out (gate response), busy (DRIVE/SAMPLE), done (one-cycle end pulse), pass (last sweep clean),
//        err_count (mismatches), first_fail (lowest mismatching vector)
// option: TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN ends the sweep on the first mismatch
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int                N_IN     = 2,
  parameter logic [2**N_IN-1:0] EXPECTED = 4'b1000,
  parameter int                SETTLE   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail
);
  state_t state;
  logic zero, mism, last, stop;
  logic [N_IN:0] err_next;
  assign mism = dut_out != EXPECTED[dut_in];
  assign last = &dut_in;
  assign err_next = err_count + (N_IN+1)'(mism);
  assign busy = state == DRIVE || state == SAMPLE;
  assign done = state == DONE;
`ifdef TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN
  assign stop = mism;
`else
  assign stop = 1'b0;
`endif
  settle_counter u_cnt (
    .clk,
    .rst,
    .load    ((state == IDLE && start) || state == SAMPLE),
    .en      (state == DRIVE),
    .load_val(CNT_W'(SETTLE)),
    .zero
  );
  // pass is resolved on entry to DONE so it is valid alongside the done pulse
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      dut_in     <= '0;
      err_count  <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else unique case (state)
      IDLE: if (start) begin
        state      <= DRIVE;
        dut_in     <= '0;
        err_count  <= '0;
        first_fail <= '0;
        pass       <= 1'b0;
      end
      DRIVE: if (zero) state <= SAMPLE;
      SAMPLE: begin
        err_count <= err_next;
        if (mism && err_count == '0) first_fail <= dut_in;
        if (last || stop) begin
          state <= DONE;
          pass  <= err_next == '0;
        end else begin
          state  <= DRIVE;
          dut_in <= dut_in + N_IN'(1);
        end
      end
      DONE: state <= IDLE;
    endcase
endmodule
